// File: rtl/ocm_coeff_loader_pkg.sv
// Shared word/lane layout and loader state encoding for the OCM pulse-response path.
// Also used by the channel-side reader so both agree on lane order.
package ocm_pkg;
  localparam int SIGNAL_RESOLUTION = 8;
  localparam int OCM_DATA_W        = 64;
  localparam int OCM_ADDR_W        = 14;
  localparam int OCM_LANES         = OCM_DATA_W / SIGNAL_RESOLUTION;
  localparam int LANE_W            = $clog2(OCM_LANES);
  localparam int ADDR_STEP         = 4;
  localparam int MAX_WORDS         = 256;
  localparam int NUM_W             = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/ocm_coeff_loader_if.sv
// Byte-source / OCM port-2 bundle of the coefficient loader; master = host side, slave = loader.
// Optional checksum output present when OCM_LOADER_CHECKSUM_EN is defined.
interface ocm_coeff_loader_if;
  import ocm_pkg::*;

  logic                         start;
  logic [OCM_ADDR_W-1:0]        base_addr;
  logic [NUM_W-1:0]             num_words;
  logic [SIGNAL_RESOLUTION-1:0] byte_in;
  logic                         byte_valid;
  logic                         byte_last;
  logic                         byte_ready;
  logic [OCM_ADDR_W-1:0]        addr2;
  logic                         wen2;
  logic [OCM_DATA_W-1:0]        writedata2;
  logic [OCM_LANES-1:0]         byteenable2;
  logic [7:0]                   location;
  logic                         busy;
  logic                         load_done;
`ifdef OCM_LOADER_CHECKSUM_EN
  logic [OCM_DATA_W-1:0]        checksum;
`endif

  modport master (
`ifdef OCM_LOADER_CHECKSUM_EN
    input  checksum,
`endif
    output start, base_addr, num_words, byte_in, byte_valid, byte_last,
    input  byte_ready, addr2, wen2, writedata2, byteenable2, location, busy, load_done
  );

  modport slave (
`ifdef OCM_LOADER_CHECKSUM_EN
    output checksum,
`endif
    input  start, base_addr, num_words, byte_in, byte_valid, byte_last,
    output byte_ready, addr2, wen2, writedata2, byteenable2, location, busy, load_done
  );
endinterface

// File: rtl/ocm_coeff_loader_byte_packer.sv
// Packs accepted bytes into a 64-bit word, lane 0 first; the merged word is presented
// combinationally so the loader can latch it on the completing byte.
module ocm_byte_packer
  import ocm_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear_i,
  input  logic                         accept_i,
  input  logic [SIGNAL_RESOLUTION-1:0] byte_i,
  input  logic                         last_i,
  output logic [OCM_DATA_W-1:0]        word_dat_o,
  output logic [OCM_LANES-1:0]         word_be_o,
  output logic                         word_full_o,
  output logic                         last_seen_o
);
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [OCM_DATA_W-1:0] data_q, data_d, merged_dat;
  logic [OCM_LANES-1:0]  mask_q, mask_d, merged_be;
  logic                  last_q, last_d;

  always_comb begin
    merged_dat = data_q;
    merged_dat[lane_q*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION] = byte_i;
    merged_be  = mask_q | (OCM_LANES'(1) << lane_q);
  end

  assign word_full_o = accept_i && ((lane_q == LANE_W'(OCM_LANES - 1)) || last_i);
  assign word_dat_o  = merged_dat;
  assign word_be_o   = merged_be;
  assign last_seen_o = last_q;

  // A completed word restarts from zero so a short final word has clean upper lanes.
  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    mask_d = mask_q;
    last_d = last_q;
    if (clear_i) begin
      lane_d = '0;
      data_d = '0;
      mask_d = '0;
      last_d = 1'b0;
    end else if (accept_i) begin
      last_d = last_q | last_i;
      if (word_full_o) begin
        lane_d = '0;
        data_d = '0;
        mask_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        data_d = merged_dat;
        mask_d = merged_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      mask_q <= mask_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/ocm_coeff_loader.sv
// Packs a coefficient byte stream into 64-bit words and writes them to OCM port 2 at stepped addresses.
// Build option OCM_LOADER_CHECKSUM_EN adds an XOR checksum of all written words.
module ocm_coeff_loader
  import ocm_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  ocm_coeff_loader_if.slave  bus
);
  loader_state_t         state_q;
  logic [OCM_ADDR_W-1:0] base_q, addr2_q;
  logic [NUM_W-1:0]      num_q, words_q;
  logic                  wen2_q, load_done_q, busy_q, rdy_q;
  logic [OCM_DATA_W-1:0] wdata_q;
  logic [OCM_LANES-1:0]  be_q;
`ifdef OCM_LOADER_CHECKSUM_EN
  logic [OCM_DATA_W-1:0] checksum_q;
`endif

  logic                  start_acc, accept, word_full, last_seen;
  logic [OCM_DATA_W-1:0] word_dat;
  logic [OCM_LANES-1:0]  word_be;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign accept    = bus.byte_valid && rdy_q;

  ocm_byte_packer u_packer (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (start_acc),
    .accept_i    (accept),
    .byte_i      (bus.byte_in),
    .last_i      (bus.byte_last),
    .word_dat_o  (word_dat),
    .word_be_o   (word_be),
    .word_full_o (word_full),
    .last_seen_o (last_seen)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      words_q     <= '0;
      addr2_q     <= '0;
      wen2_q      <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
`ifdef OCM_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          base_q  <= bus.base_addr;
          num_q   <= bus.num_words;
          words_q <= '0;
          busy_q  <= 1'b1;
          rdy_q   <= (bus.num_words != '0);
          state_q <= FILL;
`ifdef OCM_LOADER_CHECKSUM_EN
          checksum_q <= '0;
`endif
        end
        FILL: begin
          // A zero-length load passes through FILL without ever raising byte_ready.
          if (num_q == '0) begin
            load_done_q <= 1'b1;
            state_q     <= DONE;
          end else if (word_full) begin
            rdy_q   <= 1'b0;
            wen2_q  <= 1'b1;
            addr2_q <= base_q + OCM_ADDR_W'(words_q) * OCM_ADDR_W'(ADDR_STEP);
            wdata_q <= word_dat;
            be_q    <= word_be;
            words_q <= words_q + 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          wen2_q <= 1'b0;
          be_q   <= '0;
`ifdef OCM_LOADER_CHECKSUM_EN
          checksum_q <= checksum_q ^ wdata_q;
`endif
          if ((words_q < num_q) && !last_seen) begin
            rdy_q   <= 1'b1;
            state_q <= FILL;
          end else begin
            load_done_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          load_done_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready  = rdy_q;
  assign bus.addr2       = addr2_q;
  assign bus.wen2        = wen2_q;
  assign bus.writedata2  = wdata_q;
  assign bus.byteenable2 = be_q;
  assign bus.location    = words_q[7:0];
  assign bus.busy        = busy_q;
  assign bus.load_done   = load_done_q;
`ifdef OCM_LOADER_CHECKSUM_EN
  assign bus.checksum    = checksum_q;
`endif
endmodule

// File: tb/tb_ocm_coeff_loader.sv
// Directed and randomized loads of ocm_coeff_loader checked against a word-list reference model.
// Checksum comparisons are included when OCM_LOADER_CHECKSUM_EN is defined.
module tb_ocm_coeff_loader;
  import ocm_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ocm_coeff_loader_if bus();
  ocm_coeff_loader dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [13:0] addr;
    logic [63:0] dat;
    logic [7:0]  be;
    int          cyc;
    int          end_idx;
  } wr_t;

  wr_t         wr_q[$];
  int          acc_q[$];
  int          cyc = 0, ld_cnt = 0, ld_cyc = 0, start_cyc = 0;
  logic        busy_at_ld = 1'b0;
  logic [63:0] cks_at_ld = '0;
  int          n_cmp = 0, n_err = 0;
  logic [7:0]  q[$];

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (bus.wen2) begin
      w.addr = bus.addr2; w.dat = bus.writedata2; w.be = bus.byteenable2;
      w.cyc = cyc; w.end_idx = 0;
      wr_q.push_back(w);
    end
    if (bus.byte_valid && bus.byte_ready) acc_q.push_back(cyc);
    if (bus.start && !bus.busy) start_cyc = cyc;
    if (bus.load_done) begin
      ld_cnt++;
      ld_cyc = cyc;
      busy_at_ld = bus.busy;
`ifdef OCM_LOADER_CHECKSUM_EN
      cks_at_ld = bus.checksum;
`endif
    end
  end

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Reference: chop the stream into 8-byte words, stop at num words.
  task automatic model(input logic [13:0] base, input int num, input logic [7:0] b[$], output wr_t exp[$]);
    int nb = b.size();
    exp.delete();
    for (int w = 0; (w < num) && (w * 8 < nb); w++) begin
      wr_t e;
      e.addr = 14'((int'(base) + ADDR_STEP * w) % 16384);
      e.dat = '0; e.be = '0; e.cyc = 0;
      e.end_idx = (w * 8 + 7 < nb) ? w * 8 + 7 : nb - 1;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < nb) begin
          e.dat[8*k +: 8] = b[w*8+k];
          e.be[k] = 1'b1;
        end
      exp.push_back(e);
    end
  endtask

  task automatic drive_stream(input logic [7:0] b[$], input bit has_last, input bit gaps, input int poke_idx);
    for (int i = 0; i < b.size(); i++) begin
      int waitc;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.byte_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b[i];
      bus.byte_last  = has_last && (i == b.size() - 1);
      if (i == poke_idx) begin
        bus.start = 1'b1; bus.base_addr = 14'h2AA; bus.num_words = 9'd7;
      end
      waitc = 0;
      forever begin
        @(negedge clk);
        if (bus.byte_ready) break;
        waitc++;
        if (waitc > 64) break;
      end
      if (waitc > 64) begin
        n_cmp++; n_err++;
        $error("FAIL stream.accept_timeout observed=no byte_ready expected=byte %0d accepted", i);
        break;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [13:0] base, input logic [8:0] num,
                          input logic [7:0] b[$], input bit has_last, input bit gaps,
                          input int poke_idx, input bit edge_cases);
    wr_t         exp[$];
    int          w0, a0, l0, waitc;
    logic [63:0] cks = '0;
    model(base, int'(num), b, exp);
    @(posedge clk); #1;
    w0 = wr_q.size(); a0 = acc_q.size(); l0 = ld_cnt;
    bus.start = 1'b1; bus.base_addr = base; bus.num_words = num;
    if (edge_cases) begin bus.byte_valid = 1'b1; bus.byte_in = 8'hA5; end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.byte_valid = 1'b0;
    if (num != 0) drive_stream(b, has_last, gaps, poke_idx);
    if (edge_cases) begin
      bus.byte_valid = 1'b1; bus.byte_in = 8'hEE;
      repeat (6) @(posedge clk);
      #1; bus.byte_valid = 1'b0;
    end
    waitc = 0;
    while ((ld_cnt == l0) && (waitc < 300)) begin @(negedge clk); waitc++; end
    repeat (3) @(negedge clk);
    chk(tag, "load_done_pulses", ld_cnt - l0, 1);
    chk(tag, "num_writes", wr_q.size() - w0, exp.size());
    chk(tag, "bytes_accepted", acc_q.size() - a0, b.size());
    for (int i = 0; (i < exp.size()) && (w0 + i < wr_q.size()); i++) begin
      chk(tag, $sformatf("w%0d.addr2", i), wr_q[w0+i].addr, exp[i].addr);
      chk(tag, $sformatf("w%0d.writedata2", i), wr_q[w0+i].dat, exp[i].dat);
      chk(tag, $sformatf("w%0d.byteenable2", i), wr_q[w0+i].be, exp[i].be);
      if (a0 + exp[i].end_idx < acc_q.size())
        chk(tag, $sformatf("w%0d.latency", i), wr_q[w0+i].cyc, acc_q[a0+exp[i].end_idx] + 1);
      cks = cks ^ exp[i].dat;
    end
    if (exp.size() == 0) chk(tag, "done_cycle", ld_cyc, start_cyc + 2);
    else if (wr_q.size() > w0) chk(tag, "done_cycle", ld_cyc, wr_q[wr_q.size()-1].cyc + 1);
    chk(tag, "location", bus.location, 8'(exp.size()));
    chk(tag, "busy_at_done", busy_at_ld, 1);
    chk(tag, "busy_after", bus.busy, 0);
    chk(tag, "byte_ready_after", bus.byte_ready, 0);
`ifdef OCM_LOADER_CHECKSUM_EN
    chk(tag, "checksum", cks_at_ld, cks);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, "addr2", bus.addr2, 0);
    chk(tag, "wen2", bus.wen2, 0);
    chk(tag, "writedata2", bus.writedata2, 0);
    chk(tag, "byteenable2", bus.byteenable2, 0);
    chk(tag, "location", bus.location, 0);
    chk(tag, "busy", bus.busy, 0);
    chk(tag, "load_done", bus.load_done, 0);
    chk(tag, "byte_ready", bus.byte_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, num, nb;
    bit hl;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;

    q = {};
    for (int k = 1; k <= 8; k++) q.push_back(8'(k * 8'h11));
    run_load("full_word", 14'h010, 9'd1, q, 1'b0, 1'b0, -1, 1'b1);

    q = {};
    for (int k = 0; k < 24; k++) q.push_back(8'($urandom));
    run_load("multi_word", 14'h000, 9'd3, q, 1'b0, 1'b1, -1, 1'b1);

    q = {};
    for (int k = 0; k < 11; k++) q.push_back(8'($urandom));
    run_load("early_end", 14'h020, 9'd4, q, 1'b1, 1'b0, -1, 1'b0);

    q = {};
    run_load("zero_len", 14'h123, 9'd0, q, 1'b0, 1'b0, -1, 1'b0);

    q = {};
    for (int k = 0; k < 16; k++) q.push_back(8'($urandom));
    run_load("busy_start", 14'h100, 9'd2, q, 1'b0, 1'b1, 3, 1'b0);

    run_load("wrap", 14'h3FFC, 9'd2, q, 1'b0, 1'b0, -1, 1'b0);

    q = {};
    for (int k = 0; k < 7; k++) q.push_back(8'h00);
    q.push_back(8'hFF);
    for (int k = 0; k < 7; k++) q.push_back(8'hFF);
    q.push_back(8'h00);
    run_load("checksum_pair", 14'h040, 9'd2, q, 1'b0, 1'b0, -1, 1'b0);

    // Reset in the middle of a word must abandon the load silently.
    @(posedge clk); #1;
    w0 = wr_q.size();
    bus.start = 1'b1; bus.base_addr = 14'h200; bus.num_words = 9'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    q = {8'h01, 8'h02, 8'h03};
    drive_stream(q, 1'b0, 1'b0, -1);
    #2 rstn = 1'b0;
    #2 chk_zero("midload_reset");
    repeat (3) @(negedge clk);
    chk("midload_reset", "writes_during_reset", wr_q.size() - w0, 0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int r = 0; r < 5; r++) begin
      num = $urandom_range(1, 5);
      nb  = $urandom_range(1, num * 8);
      hl  = (nb < num * 8) ? 1'b1 : 1'($urandom_range(0, 1));
      q = {};
      for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r), 14'($urandom), 9'(num), q, hl, 1'b1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
